// File: rtl/pmem_types.sv
// Shared types and constants for the pmem responder model.
package pmem_types;

    localparam int unsigned LINE_WIDTH  = 256;
    localparam int unsigned OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_state_e;

endpackage

// File: rtl/pmem_array.sv
// Line storage: 2**INDEX_BITS lines of LINE_WIDTH bits, synchronous write and
// combinational read. Contents survive reset; they start at zero only at elaboration.
module pmem_array
    import pmem_types::*;
#(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [LINE_WIDTH-1:0] wdata_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic [LINE_WIDTH-1:0] rdata_o
);

    logic [LINE_WIDTH-1:0] mem_q [2**INDEX_BITS] = '{default: '0};

    // Line write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_idx_i];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder: accepts one read or write, answers with a
// single-cycle pmem_resp exactly LATENCY cycles later, and flags protocol misuse.
module pmem_responder
    import pmem_types::*;
#(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [31:0]           pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  proto_err,
    output logic [15:0]           read_count,
    output logic [15:0]           write_count
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

    pmem_state_e           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic                  is_wr_q, is_wr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_q, resp_d;
    logic                  perr_q, perr_d;
    logic [15:0]           rcnt_q, rcnt_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic [LINE_WIDTH-1:0] mem_rdata_s;
    logic                  commit_s;

    // A write lands at the end of its RESP cycle unless reset abandons it there.
    assign commit_s = (state_q == RESP) && is_wr_q && !reset;

    pmem_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk      (clk),
        .we_i     (commit_s),
        .wr_idx_i (idx_q),
        .wdata_i  (wdata_q),
        .rd_idx_i (idx_q),
        .rdata_o  (mem_rdata_s)
    );

    // Next-state logic; resp and rdata are computed one cycle ahead so both leave on flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        is_wr_d = is_wr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        resp_d  = 1'b0;
        perr_d  = perr_q;
        rcnt_d  = rcnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    idx_d   = pmem_address[OFFSET_BITS +: INDEX_BITS];
                    is_wr_d = pmem_write;
                    wdata_d = pmem_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                    if (pmem_read && pmem_write) begin
                        perr_d = 1'b1;
                    end else begin
                        perr_d = perr_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!(pmem_read || pmem_write)) begin
                    state_d = IDLE;
                    perr_d  = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    rdata_d = is_wr_q ? '0 : mem_rdata_s;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (is_wr_q) begin
                    wcnt_d = wcnt_q + 16'd1;
                end else begin
                    rcnt_d = rcnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latches and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            is_wr_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            perr_q  <= 1'b0;
            rcnt_q  <= 16'd0;
            wcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            is_wr_q <= is_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            perr_q  <= perr_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign pmem_rdata  = rdata_q;
    assign pmem_resp   = resp_q;
    assign proto_err   = perr_q;
    assign read_count  = rcnt_q;
    assign write_count = wcnt_q;

endmodule
